// File: rtl/video_timing_gen.sv
// Raster timing generator feeding the HDMI encoder: counts a programmable H/V raster, pulls one
// pixel per active clock and drives registered RGB/sync/de. Optional macro: TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Sync windows are expressed as inclusive ranges so every bound fits the counter width.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [23:0]   r_rgb;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic          r_frame_start;
  logic          r_underrun;

  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          w_first;
  logic [23:0]   w_fill;

  assign w_active  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs      = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vs      = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
  assign w_first   = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign pix_ready = reset_n && w_active;

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar;
  assign w_bar = 3'(r_h_cnt / HW'(BAR_W));

  always_comb begin
    w_fill = 24'h000000;
    case (w_bar)
      3'd0:    w_fill = 24'hFFFFFF;
      3'd1:    w_fill = 24'hFFFF00;
      3'd2:    w_fill = 24'h00FFFF;
      3'd3:    w_fill = 24'h00FF00;
      3'd4:    w_fill = 24'hFF00FF;
      3'd5:    w_fill = 24'hFF0000;
      3'd6:    w_fill = 24'h0000FF;
      default: w_fill = 24'h000000;
    endcase
  end
`else
  assign w_fill = 24'h000000;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_rgb         <= '0;
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end

      // The raster never stalls: a missing pixel is replaced by the fill colour.
      r_de          <= w_active;
      r_rgb         <= !w_active ? 24'h000000 : (pix_valid ? pix_data : w_fill);
      r_hsync       <= w_hs ? HS_POL : !HS_POL;
      r_vsync       <= w_vs ? VS_POL : !VS_POL;
      r_frame_start <= w_first;

      // A gap on the very first pixel must survive the frame_start clear.
      if (w_active && !pix_valid) begin
        r_underrun <= 1'b1;
      end else if (w_first) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign R           = r_rgb[23:16];
  assign G           = r_rgb[15:8];
  assign B           = r_rgb[7:0];
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing and pixel-stream stage that sits directly upstream of the HDMI output encoder. It counts a programmable horizontal/vertical raster, pulls one 24-bit pixel per active clock from an upstream pixel source over a valid/ready handshake, and drives the registered R/G/B, hsync, vsync and de that the HDMI output consumes on the same pixel clock. Underruns are flagged and filled so the TMDS stream never loses sync.

## Interface
Parameters:
- H_ACTIVE, 800, active pixels per line; must be a multiple of 8.
- H_FP, 40, horizontal front porch in clocks.
- H_SYNC, 128, hsync pulse width in clocks.
- H_BP, 88, horizontal back porch in clocks.
- V_ACTIVE, 600, active lines per frame.
- V_FP, 1, vertical front porch in lines.
- V_SYNC, 4, vsync pulse width in lines.
- V_BP, 23, vertical back porch in lines.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.
- Constraint: H_FP+H_SYNC+H_BP >= 12, covering the HDMI video preamble and guard band.

Ports:
- clk  input  1  pixel clock, the same clock as the HDMI output's clk.
- reset_n  input  1  synchronous, active-low reset.
- pix_data  input  24  pixel from the upstream source: [23:16]=R, [15:8]=G, [7:0]=B.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  the block consumes pix_data this cycle.
- R, G, B  output  8 each  registered pixel colour.
- hsync  output  1  registered horizontal sync at HS_POL.
- vsync  output  1  registered vertical sync at VS_POL.
- de  output  1  registered display enable.
- frame_start  output  1  one-clock pulse, aligned with the first active pixel of a frame.
- underrun  output  1  sticky; set when an active pixel was missing in the current frame.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 and wraps to 0. Counter widths are sized by $clog2 of the totals.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- pix_ready = reset_n && active. It is combinational from the counters and does not depend on pix_valid. A pixel transfers when pix_valid && pix_ready.
- Active cycle with pix_valid=1: {R,G,B} <= pix_data.
- Active cycle with pix_valid=0: {R,G,B} <= fill (see Configuration), and underrun is set. There is no stall: the raster always advances.
- Blanking cycle: {R,G,B} <= 0, de <= 0. pix_valid is ignored and nothing is consumed.
- hsync asserts while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync asserts for whole lines while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. Its edges therefore coincide with h_cnt=0.
- de is never asserted on vsync lines. This leaves the downstream data-island window (hsync falling edge while vsync is asserted) free of video.
- underrun is cleared on the cycle frame_start is issued. If the (0,0) pixel itself underruns, set wins.
- Reset (reset_n=0 at a clock edge), including mid-frame:
  - h_cnt=v_cnt=0.
  - de=0, R=G=B=0.
  - hsync=!HS_POL, vsync=!VS_POL.
  - frame_start=0, underrun=0.
  - pix_ready=0.

## Timing
- Outputs are registered with exactly 1 clock of latency from the counter state. A pixel accepted at counter (h,v) appears on R/G/B with de=1 on the next clock.
- First clock after reset_n rises: counters at (0,0) and pix_ready=1. Next clock: de=1 and frame_start=1.
- Per line: de is high for H_ACTIVE consecutive clocks, then low for H_FP clocks before hsync asserts.
- Each frame is exactly H_TOTAL*V_TOTAL clocks. frame_start pulses once per frame.

## Configuration
- TEST_PATTERN_EN defined: fill is 8 vertical colour bars indexed by h_cnt/(H_ACTIVE/8). Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- TEST_PATTERN_EN undefined: fill is 000000. No bar logic is present.
- Underrun flagging is identical in both builds.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=7, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (H_TOTAL=20, V_TOTAL=8).

- Reset release, pix_valid tied 1, pix_data = incrementing count from 0 -> de high 8 clocks per line, beginning 1 clock after release. R/G/B show 0..7 on line 0. frame_start pulses every 160 clocks.
- Sync placement -> hsync high for exactly clocks h=10..12 of each line, delayed by 1 clock. vsync high for lines 5..6. No de on those lines.
- pix_valid dropped for one active clock at line 2, h=3 -> that output pixel equals fill and underrun rises. underrun stays high until the next frame_start and then clears, provided the next frame has no gaps.
- Build with TEST_PATTERN_EN and pix_valid=0 -> each active pixel h shows bar h (bar width 1): FFFFFF, FFFF00, …, 000000. Built without the macro -> all 000000.
- HS_POL=0, VS_POL=0 -> idle and reset levels of hsync/vsync are 1, and the pulses are low.
- reset_n pulsed low for one clock mid-line (line 1, h=5) -> next clock shows de=0, syncs inactive, underrun=0. The raster restarts at (0,0) with frame_start following.
